// File: rtl/bsearch_probe.sv
// bsearch_probe: sequential binary-search initiator.
// Presents guesses to a magnitude comparator (guess = operand A), narrows a
// [lo, hi] window from the returned gt/eq/lt flags and reports the located
// value, a not-found outcome, or an error on a malformed flag vector.

module bsearch_probe #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_vld,
    input  logic             res_vld,
    input  logic [3:0]       flags,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps
);

    // Search controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Classified comparator response.
    typedef enum logic [1:0] {
        RSP_EQ  = 2'd0,
        RSP_GT  = 2'd1,
        RSP_LT  = 2'd2,
        RSP_BAD = 2'd3
    } rsp_t;

    // Window bounds are one bit wider than the guess so that lo can step past
    // the top of the range and hi can never wrap below zero unnoticed.
    localparam logic [WIDTH:0]   LO_INIT  = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] MID_INIT = HI_INIT[WIDTH:1];
    localparam logic [WIDTH-1:0] GMIN     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] GMAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [SW-1:0]    ONE_STEP = {{(SW-1){1'b0}}, 1'b1};

    // Exactly one of gt/eq/lt must be set; anything else is malformed.
    // Bit 3 of the flag vector is deliberately not consulted.
    function automatic rsp_t decode_flags(input logic [2:0] f);
        rsp_t r;
        case (f)
            3'b010:  r = RSP_EQ;
            3'b100:  r = RSP_GT;
            3'b001:  r = RSP_LT;
            default: r = RSP_BAD;
        endcase
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH:0]   lo_r;
    logic [WIDTH:0]   hi_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mid_s;
    logic [WIDTH:0]   guess_ext_s;
    logic [WIDTH:0]   hi_dec_s;
    logic [WIDTH:0]   lo_inc_s;
    logic             at_floor_s;
    logic             at_ceil_s;
    logic             window_empty_s;
    rsp_t             rsp_s;
    logic [1:0]       unused_bits_s;

    // Datapath: midpoint, narrowed bounds, boundary and empty-window tests.
    always_comb begin
        sum_s          = lo_r + hi_r;
        mid_s          = sum_s[WIDTH:1];
        guess_ext_s    = {1'b0, guess};
        hi_dec_s       = guess_ext_s - ONE_EXT;
        lo_inc_s       = guess_ext_s + ONE_EXT;
        rsp_s          = decode_flags(flags[2:0]);
        unused_bits_s  = {flags[3], sum_s[0]};
        if (guess == GMIN) begin
            at_floor_s = 1'b1;
        end else begin
            at_floor_s = 1'b0;
        end
        if (guess == GMAX) begin
            at_ceil_s = 1'b1;
        end else begin
            at_ceil_s = 1'b0;
        end
        if (lo_r > hi_r) begin
            window_empty_s = 1'b1;
        end else begin
            window_empty_s = 1'b0;
        end
    end

    // Search FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            lo_r      <= LO_INIT;
            hi_r      <= HI_INIT;
            guess     <= {WIDTH{1'b0}};
            guess_vld <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            err       <= 1'b0;
            result    <= {WIDTH{1'b0}};
            steps     <= {SW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lo_r      <= LO_INIT;
                        hi_r      <= HI_INIT;
                        steps     <= {SW{1'b0}};
                        found     <= 1'b0;
                        err       <= 1'b0;
                        guess     <= MID_INIT;
                        guess_vld <= 1'b1;
                        state_r   <= PROBE;
                    end else begin
                        guess_vld <= 1'b0;
                    end
                end
                PROBE: begin
                    // Guess is frozen here until the responder answers.
                    if (res_vld) begin
                        steps     <= steps + ONE_STEP;
                        guess_vld <= 1'b0;
                        case (rsp_s)
                            RSP_EQ: begin
                                found   <= 1'b1;
                                result  <= guess;
                                done    <= 1'b1;
                                state_r <= DONE;
                            end
                            RSP_GT: begin
                                if (at_floor_s) begin
                                    done    <= 1'b1;
                                    state_r <= DONE;
                                end else begin
                                    hi_r    <= hi_dec_s;
                                    state_r <= CALC;
                                end
                            end
                            RSP_LT: begin
                                if (at_ceil_s) begin
                                    done    <= 1'b1;
                                    state_r <= DONE;
                                end else begin
                                    lo_r    <= lo_inc_s;
                                    state_r <= CALC;
                                end
                            end
                            default: begin
                                err     <= 1'b1;
                                found   <= 1'b0;
                                done    <= 1'b1;
                                state_r <= DONE;
                            end
                        endcase
                    end else begin
                        guess_vld <= 1'b1;
                    end
                end
                CALC: begin
                    // An inconsistent responder can empty the window.
                    if (window_empty_s) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        guess     <= mid_s;
                        guess_vld <= 1'b1;
                        state_r   <= PROBE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    guess_vld <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    guess_vld <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
